// File: rtl/zero_mem_bridge.sv
// zero_mem_bridge: single-port bridge between the zerocore fetch/LSU request
// ports and the simulation RAMHelper.
//
// Ports
//   clk, rst               core clock, asynchronous active-low reset
//   if_req_*  / if_resp_*  instruction fetch request / one-cycle response
//   d_req_*   / d_resp_*   load/store request / one-cycle response
//   ram_*                  RAMHelper read (combinational) and write ports
//
// One request is accepted per cycle. When both requesters are valid, the one
// not granted last wins. Byte addresses become 64-bit word indices relative
// to MEM_BASE. Responses are registered and appear in the cycle after accept.
module zero_mem_bridge #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_wen,
  input  logic [63:0] d_req_addr,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_unsigned,
  input  logic [63:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_rdata,
  output logic        d_resp_err,

  output logic        ram_ren,
  output logic [63:0] ram_rIdx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_wIdx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);

  typedef enum logic {GrantIf, GrantD} grantT;

  grantT       lastGrantQ;
  logic        ifRespValidQ, dRespValidQ;
  logic [31:0] ifRespDataQ;
  logic [63:0] dRespDataQ;
  logic        ifRespErrQ, dRespErrQ;

  logic        ifReady, dReady;
  logic        ifErr, dErr, dMisalign;
  logic [63:0] ifIdx, dIdx;
  logic [31:0] ifInstr;
  logic [5:0]  dShift;
  logic [63:0] sizeMask;
  logic [63:0] loadShifted;
  logic [63:0] loadExt;

  // Arbiter: readies are forced low in reset so nothing is accepted or written.
  always_comb begin
    ifReady = 1'b0;
    dReady  = 1'b0;
    if (rst) begin
      if (if_req_valid && d_req_valid) begin
        if (lastGrantQ == GrantIf) begin
          dReady = 1'b1;
        end else begin
          ifReady = 1'b1;
        end
      end else begin
        ifReady = if_req_valid;
        dReady  = d_req_valid;
      end
    end
  end

  assign if_req_ready = ifReady;
  assign d_req_ready  = dReady;

  // Address decode
  assign ifIdx  = (if_req_addr - MEM_BASE) >> 3;
  assign dIdx   = (d_req_addr - MEM_BASE) >> 3;
  assign ifErr  = (if_req_addr < MEM_BASE) || (if_req_addr[1:0] != 2'b00);
  assign dShift = {d_req_addr[2:0], 3'b000};

  always_comb begin
    dMisalign = 1'b0;
    sizeMask  = 64'hFFFF_FFFF_FFFF_FFFF;
    case (d_req_size)
      2'd0: begin
        dMisalign = 1'b0;
        sizeMask  = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        dMisalign = d_req_addr[0];
        sizeMask  = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        dMisalign = |d_req_addr[1:0];
        sizeMask  = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        dMisalign = |d_req_addr[2:0];
        sizeMask  = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  assign dErr = (d_req_addr < MEM_BASE) || dMisalign;

  // Load alignment and extension
  assign loadShifted = ram_rdata >> dShift;

  always_comb begin
    loadExt = loadShifted;
    case (d_req_size)
      2'd0: loadExt = d_req_unsigned ? {56'h0, loadShifted[7:0]}
                                     : {{56{loadShifted[7]}}, loadShifted[7:0]};
      2'd1: loadExt = d_req_unsigned ? {48'h0, loadShifted[15:0]}
                                     : {{48{loadShifted[15]}}, loadShifted[15:0]};
      2'd2: loadExt = d_req_unsigned ? {32'h0, loadShifted[31:0]}
                                     : {{32{loadShifted[31]}}, loadShifted[31:0]};
      default: loadExt = loadShifted;
    endcase
  end

  assign ifInstr = if_req_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];

  // RAM port drive; errored requests are accepted but never touch the RAM.
  always_comb begin
    ram_ren   = 1'b0;
    ram_rIdx  = 64'h0;
    ram_wen   = 1'b0;
    ram_wIdx  = 64'h0;
    ram_wdata = 64'h0;
    ram_wmask = 64'h0;
    if (ifReady && !ifErr) begin
      ram_ren  = 1'b1;
      ram_rIdx = ifIdx;
    end else if (dReady && !dErr) begin
      if (d_req_wen) begin
        ram_wen   = 1'b1;
        ram_wIdx  = dIdx;
        ram_wdata = d_req_wdata << dShift;
        ram_wmask = sizeMask << dShift;
      end else begin
        ram_ren  = 1'b1;
        ram_rIdx = dIdx;
      end
    end
  end

  // Response registers; a pending response is dropped by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrantQ   <= GrantIf;
      ifRespValidQ <= 1'b0;
      ifRespDataQ  <= 32'h0;
      ifRespErrQ   <= 1'b0;
      dRespValidQ  <= 1'b0;
      dRespDataQ   <= 64'h0;
      dRespErrQ    <= 1'b0;
    end else begin
      ifRespValidQ <= ifReady;
      dRespValidQ  <= dReady;
      if (ifReady) begin
        lastGrantQ  <= GrantIf;
        ifRespDataQ <= ifErr ? 32'h0 : ifInstr;
        ifRespErrQ  <= ifErr;
      end
      if (dReady) begin
        lastGrantQ <= GrantD;
        dRespDataQ <= (dErr || d_req_wen) ? 64'h0 : loadExt;
        dRespErrQ  <= dErr;
      end
    end
  end

  assign if_resp_valid = ifRespValidQ;
  assign if_resp_data  = ifRespDataQ;
  assign if_resp_err   = ifRespErrQ;
  assign d_resp_valid  = dRespValidQ;
  assign d_resp_rdata  = dRespDataQ;
  assign d_resp_err    = dRespErrQ;

endmodule

// File: tb/tb_zero_mem_bridge.sv
// Scoreboard bench for zero_mem_bridge: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response valid is seen.
module tb_zero_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_err;
  logic        d_req_valid, d_req_ready, d_req_wen, d_req_unsigned;
  logic [63:0] d_req_addr, d_req_wdata;
  logic [1:0]  d_req_size;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;
  logic        ram_ren, ram_wen;
  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } expT;

  expT  ifQ[$];
  expT  dQ[$];
  logic orderQ[$];  // 0 = fetch response, 1 = data response

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [16] = '{64'h1122_3344_5566_7788, 64'h0123_4567_89AB_CDEF,
                            64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                            64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};

  always #5 clk = ~clk;

  assign ram_rdata = (ram_rIdx < 64'd16) ? mem[ram_rIdx[3:0]] : 64'h0;

  always @(posedge clk) begin
    if (ram_wen && ram_wIdx < 64'd16)
      mem[ram_wIdx[3:0]] <= (mem[ram_wIdx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  zero_mem_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .if_resp_err   (if_resp_err),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_wen     (d_req_wen),
    .d_req_addr    (d_req_addr),
    .d_req_size    (d_req_size),
    .d_req_unsigned(d_req_unsigned),
    .d_req_wdata   (d_req_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_resp_rdata  (d_resp_rdata),
    .d_resp_err    (d_resp_err),
    .ram_ren       (ram_ren),
    .ram_rIdx      (ram_rIdx),
    .ram_rdata     (ram_rdata),
    .ram_wen       (ram_wen),
    .ram_wIdx      (ram_wIdx),
    .ram_wdata     (ram_wdata),
    .ram_wmask     (ram_wmask)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 1'b0;
    if_req_addr  = 64'h0;
    d_req_valid  = 1'b0;
    d_req_wen    = 1'b0;
    d_req_addr   = 64'h0;
    d_req_size   = 2'd0;
    d_req_unsigned = 1'b0;
    d_req_wdata  = 64'h0;
  endtask

  task automatic setFetch(input logic [63:0] addr);
    if_req_valid = 1'b1;
    if_req_addr  = addr;
  endtask

  task automatic setData(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata);
    d_req_valid    = 1'b1;
    d_req_wen      = wen;
    d_req_addr     = addr;
    d_req_size     = size;
    d_req_unsigned = uns;
    d_req_wdata    = wdata;
  endtask

  task automatic expIf(input logic [63:0] data, input logic err);
    ifQ.push_back('{data: data, err: err});
    orderQ.push_back(1'b0);
  endtask

  task automatic expD(input logic [63:0] data, input logic err);
    dQ.push_back('{data: data, err: err});
    orderQ.push_back(1'b1);
  endtask

  // Monitor
  initial begin
    expT  e;
    logic tag;
    forever begin
      @(negedge clk);
      if (if_resp_valid || d_resp_valid)
        check("resp_exclusive", {63'h0, if_resp_valid & d_resp_valid}, 64'h0);
      if (if_resp_valid) begin
        if (ifQ.size() == 0 || orderQ.size() == 0) begin
          check("if_resp_unexpected", 64'h1, 64'h0);
        end else begin
          e   = ifQ.pop_front();
          tag = orderQ.pop_front();
          check("if_resp_order", {63'h0, tag}, 64'h0);
          check("if_resp_data", {32'h0, if_resp_data}, e.data);
          check("if_resp_err", {63'h0, if_resp_err}, {63'h0, e.err});
        end
      end
      if (d_resp_valid) begin
        if (dQ.size() == 0 || orderQ.size() == 0) begin
          check("d_resp_unexpected", 64'h1, 64'h0);
        end else begin
          e   = dQ.pop_front();
          tag = orderQ.pop_front();
          check("d_resp_order", {63'h0, tag}, 64'h1);
          check("d_resp_rdata", d_resp_rdata, e.data);
          check("d_resp_err", {63'h0, d_resp_err}, {63'h0, e.err});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    #2;
    // Reset state, with a store held valid during reset
    check("rst_if_resp_valid", {63'h0, if_resp_valid}, 64'h0);
    check("rst_d_resp_valid", {63'h0, d_resp_valid}, 64'h0);
    check("rst_d_resp_rdata", d_resp_rdata, 64'h0);
    setData(1'b1, 64'h8000_0000, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    check("rst_d_req_ready", {63'h0, d_req_ready}, 64'h0);
    check("rst_ram_wen", {63'h0, ram_wen}, 64'h0);
    step();
    idle();
    rst = 1'b1;

    // Fetch upper half of word 0
    setFetch(64'h8000_0004);
    #1;
    check("fetch_ready", {63'h0, if_req_ready}, 64'h1);
    check("fetch_ram_ren", {63'h0, ram_ren}, 64'h1);
    check("fetch_ram_rIdx", ram_rIdx, 64'h0);
    expIf(64'h1122_3344, 1'b0);
    step(); idle();

    setData(1'b0, 64'h8000_0000, 2'd0, 1'b0, 64'h0);  // lb
    #1;
    check("lb_ready", {63'h0, d_req_ready}, 64'h1);
    expD(64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    step(); idle();

    setData(1'b0, 64'h8000_0000, 2'd0, 1'b1, 64'h0);  // lbu
    expD(64'h88, 1'b0);
    step(); idle();

    setData(1'b0, 64'h8000_0002, 2'd1, 1'b0, 64'h0);  // lh
    expD(64'h5566, 1'b0);
    step(); idle();

    setData(1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'hBEEF);  // sh
    #1;
    check("sh_ram_wen", {63'h0, ram_wen}, 64'h1);
    check("sh_ram_wIdx", ram_wIdx, 64'h0);
    check("sh_ram_wmask", ram_wmask, 64'hFFFF_0000_0000_0000);
    check("sh_ram_wdata", ram_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_ram_ren", {63'h0, ram_ren}, 64'h0);
    expD(64'h0, 1'b0);
    step(); idle();

    setData(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);  // ld right after store
    expD(64'hBEEF_3344_5566_7788, 1'b0);
    step(); idle();

    setData(1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'h0);  // lw sign-extended
    expD(64'hFFFF_FFFF_BEEF_3344, 1'b0);
    step(); idle();
    step();

    // Contention from reset: D, IF, D
    rst = 1'b0;
    step();
    rst = 1'b1;
    setFetch(64'h8000_0000);
    setData(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'h0);
    #1;
    check("arb1_d_ready", {63'h0, d_req_ready}, 64'h1);
    check("arb1_if_ready", {63'h0, if_req_ready}, 64'h0);
    expD(64'h0123_4567_89AB_CDEF, 1'b0);
    step();
    check("arb2_if_ready", {63'h0, if_req_ready}, 64'h1);
    check("arb2_d_ready", {63'h0, d_req_ready}, 64'h0);
    expIf(64'h5566_7788, 1'b0);
    step();
    check("arb3_d_ready", {63'h0, d_req_ready}, 64'h1);
    check("arb3_if_ready", {63'h0, if_req_ready}, 64'h0);
    expD(64'h0123_4567_89AB_CDEF, 1'b0);
    step(); idle();

    // Error cases: misaligned lw, fetch below MEM_BASE, misaligned sd
    setData(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'h0);
    #1;
    check("lw_mis_ready", {63'h0, d_req_ready}, 64'h1);
    check("lw_mis_ram_ren", {63'h0, ram_ren}, 64'h0);
    expD(64'h0, 1'b1);
    step(); idle();

    setFetch(64'h7FFF_FFFC);
    #1;
    check("fetch_low_ready", {63'h0, if_req_ready}, 64'h1);
    check("fetch_low_ram_ren", {63'h0, ram_ren}, 64'h0);
    expIf(64'h0, 1'b1);
    step(); idle();

    setData(1'b1, 64'h8000_0004, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    check("sd_mis_ram_wen", {63'h0, ram_wen}, 64'h0);
    expD(64'h0, 1'b1);
    step(); idle();
    step();

    // Store accepted, then reset before its response is consumed
    setData(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678);
    step();
    setData(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    check("pre_rst_d_resp_valid", {63'h0, d_resp_valid}, 64'h1);
    rst = 1'b0;
    #1;
    check("rst_drop_d_resp_valid", {63'h0, d_resp_valid}, 64'h0);
    check("rst_hold_ram_wen", {63'h0, ram_wen}, 64'h0);
    check("rst_hold_d_req_ready", {63'h0, d_req_ready}, 64'h0);
    step();
    step();
    check("rst_mem_unchanged", mem[2], 64'hCAFE_F00D_1234_5678);
    idle();
    rst = 1'b1;
    setData(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'h0);
    expD(64'hCAFE_F00D_1234_5678, 1'b0);
    step(); idle();
    step(); step();

    check("if_queue_drained", 64'(ifQ.size()), 64'h0);
    check("d_queue_drained", 64'(dQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zero_mem_bridge.md
# zero_mem_bridge

Single-port memory bridge between the zerocore fetch/LSU request ports and the simulation RAMHelper. Each cycle it arbitrates between one instruction-fetch request and one data request and converts byte addresses to RAMHelper 64-bit word indices. Stores are issued with a shifted write mask and data; load data is aligned and extended. A registered, fixed-latency response goes back to the requester. It sits directly between the core and RAMHelper in SimTop.

## Interface
- MEM_BASE, 64'h8000_0000, byte address of RAM word index 0
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch accepted this cycle
- if_req_addr  in  64  fetch byte address
- if_resp_valid  out  1  fetch response pulse
- if_resp_data  out  32  instruction
- if_resp_err  out  1  misaligned or out of range
- d_req_valid  in  1  data request
- d_req_ready  out  1  data accepted this cycle
- d_req_wen  in  1  1 = store, 0 = load
- d_req_addr  in  64  data byte address
- d_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- d_req_unsigned  in  1  zero-extend load
- d_req_wdata  in  64  store data, LSB-aligned
- d_resp_valid  out  1  data response pulse (loads and stores)
- d_resp_rdata  out  64  extended load data
- d_resp_err  out  1  misaligned or out of range
- ram_ren  out  1  RAMHelper read enable
- ram_rIdx  out  64  read word index
- ram_rdata  in  64  combinational read data
- ram_wen  out  1  RAMHelper write enable
- ram_wIdx  out  64  write word index
- ram_wdata  out  64  shifted store data
- ram_wmask  out  64  bit mask

## Operation
- Arbiter: at most one request is accepted per cycle. The ready outputs are combinational from the valids, rst and last_grant.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not granted last; last_grant updates on every accept.
  - Reset value of last_grant = IF, so the first contention goes to data.
- Word index = (addr - MEM_BASE) >> 3; off = addr[2:0].
- Error condition: addr < MEM_BASE, or addr not aligned to its size. Fetch must be 4-byte aligned.
  - An errored request is still accepted.
  - ram_ren and ram_wen stay 0 for it.
  - The response arrives with err = 1 and data = 0.
- Fetch: ram_ren = 1, ram_rIdx = index. The instruction is rdata[63:32] if addr[2], else rdata[31:0].
- Load:
  - ram_ren = 1.
  - Compute rdata >> (off*8), then truncate to the size.
  - Sign-extend unless unsigned or size = 3.
- Store:
  - ram_wen = 1, ram_wIdx = index.
  - ram_wdata = wdata << (off*8).
  - ram_wmask = (size mask: 0xFF, 0xFFFF, 0xFFFF_FFFF or all-ones) << (off*8).
  - d_resp_rdata = 0.
- No request accepted: ram_ren = ram_wen = 0. Index and data outputs are don't-care but deterministic (0).
- Response registers capture the data (extracted in the accept cycle), the err bit and the valid bit.
- Responses have no backpressure; the core must consume them.

## Timing
- Accept in cycle N: the RAM read is combinational in N; the write commits at posedge ending N.
- Response valid in N+1 for exactly one cycle; back-to-back accepts give back-to-back responses.
- Store in N followed by a load of the same word in N+1 returns the new data (no bypass needed).
- if_resp_valid and d_resp_valid are never high together (single port).
- Reset (rst = 0, asynchronous):
  - All response valids, data and err registers clear to 0 immediately; last_grant resets to IF.
  - Ready outputs and ram_ren/ram_wen are forced to 0 while rst = 0, so no write occurs during reset even if d_req_valid = 1.
  - A response pending when reset asserts is dropped.
- First accept is possible in the first cycle with rst = 1.

## Test plan
- RAM word 0 = 0x1122334455667788; fetch 0x8000_0004 -> if_req_ready = 1; next cycle if_resp_data = 0x11223344, err = 0.
- Same word; lb 0x8000_0000 -> d_resp_rdata = 0xFFFF_FFFF_FFFF_FF88. lbu -> 0x88. lh 0x8000_0002 -> 0x5566.
- sh 0xBEEF at 0x8000_0006 -> ram_wen = 1, ram_wIdx = 0, ram_wmask = 0xFFFF_0000_0000_0000, ram_wdata = 0xBEEF_0000_0000_0000; ld 0x8000_0000 next cycle -> 0xBEEF_3344_5566_7788.
- Both valid for 3 cycles from reset -> grants D, IF, D; exactly one ready per cycle; responses follow one cycle later in the same order.
- lw 0x8000_0002 and fetch 0x7FFF_FFFC -> no ram_ren/ram_wen; each gets err = 1 with data 0 next cycle.
- Store accepted, then rst = 0 mid-cycle before the response -> d_resp_valid drops at once; with d_req_valid held during reset, ram_wen = 0 and RAM is unchanged.
